// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types, limits and legality check for the programmable clock divider
package clk_div_pkg;
  localparam int DIV_W = 8;
  typedef logic [DIV_W-1:0] div_t;
  localparam div_t DIV_MIN = 2;
  localparam div_t DEFAULT_DIV = 7;
  typedef enum logic {ST_IDLE, ST_RUN} st_t;
  function automatic logic is_legal_div(input int unsigned d);
    return d >= 32'(DIV_MIN);
  endfunction
endpackage

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control/status bundle of the divider; duty_i exists only with CLK_DIV_DUTY_PROG_EN
interface clk_div_prog_if #(parameter int W = 8);
  logic en, div_load, div_ack, div_err, busy, tick, clk_out;
  logic [W-1:0] div_i, div_cur;
`ifdef CLK_DIV_DUTY_PROG_EN
  logic [W-1:0] duty_i;
`endif
  modport master (
    output en, div_load, div_i,
`ifdef CLK_DIV_DUTY_PROG_EN
    output duty_i,
`endif
    input div_ack, div_err, div_cur, busy, tick, clk_out
  );
  modport slave (
    input en, div_load, div_i,
`ifdef CLK_DIV_DUTY_PROG_EN
    input duty_i,
`endif
    output div_ack, div_err, div_cur, busy, tick, clk_out
  );
endinterface

// File: rtl/clk_div_phase_gen.sv
// clk_div_phase_gen: registered high-phase flops fed with the next-cycle counter state
// Odd ratios stretch the high phase by half a cycle via a negedge flop (absent with CLK_DIV_DUTY_PROG_EN)
module clk_div_phase_gen
  import clk_div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_run,
  input  logic [W-1:0] i_cnt,
`ifdef CLK_DIV_DUTY_PROG_EN
  input  logic [W-1:0] i_duty,
`else
  input  logic [W-1:0] i_n,
`endif
  output logic         o_clk
);
  logic r_p;
`ifdef CLK_DIV_DUTY_PROG_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_p <= 1'b0;
    else r_p <= i_run & (i_cnt < i_duty);
  assign o_clk = r_p;
`else
  logic r_odd, r_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_p   <= 1'b0;
      r_odd <= 1'b0;
    end else begin
      r_p   <= i_run & (i_cnt < (i_n >> 1));
      r_odd <= i_n[0];
    end
  // half-cycle delayed copy of r_p; ORed in it extends the high phase to the negedge
  always_ff @(negedge clk or negedge reset_n)
    if (!reset_n) r_n <= 1'b0;
    else r_n <= r_p & r_odd;
  assign o_clk = r_p | r_n;
`endif
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable glitch-free clock divider with load/ack handshake
// Define CLK_DIV_DUTY_PROG_EN for a programmable posedge-aligned duty instead of 50%
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int W = 8,
  parameter int DEFAULT_DIV = 7
) (
  input  logic           clk,
  input  logic           reset_n,
  clk_div_prog_if.slave  bus
);
  localparam logic [W-1:0] DEF_N = W'(DEFAULT_DIV);
  st_t r_st, w_st_nxt;
  logic [W-1:0] r_cnt, r_div, r_pend, w_cnt_nxt, w_div_nxt;
  logic r_busy, r_ack, r_err, w_bnd, w_legal, w_take;
`ifdef CLK_DIV_DUTY_PROG_EN
  logic [W-1:0] r_dty, r_pdty, w_dty_nxt;
  assign w_legal = is_legal_div(32'(bus.div_i)) && (bus.duty_i != '0) && (bus.duty_i < bus.div_i);
  assign w_dty_nxt = (w_bnd & r_busy) ? r_pdty : r_dty;
`else
  assign w_legal = is_legal_div(32'(bus.div_i));
`endif
  // idle counts as a boundary so a pending load lands while stopped
  assign w_bnd = (r_st == ST_IDLE) | (r_cnt == r_div - W'(1));
  assign w_take = bus.div_load & w_legal;
  always_comb begin
    w_st_nxt = ST_RUN;
    if (w_bnd && !bus.en) w_st_nxt = ST_IDLE;
    w_cnt_nxt = w_bnd ? '0 : r_cnt + W'(1);
    w_div_nxt = (w_bnd & r_busy) ? r_pend : r_div;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_st  <= ST_IDLE;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_div  <= DEF_N;
      r_pend <= DEF_N;
      r_busy <= 1'b0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_ack  <= w_bnd & r_busy;
      r_err  <= bus.div_load & ~w_legal;
      r_busy <= (r_busy & ~w_bnd) | w_take;
      if (w_take) r_pend <= bus.div_i;
    end
`ifdef CLK_DIV_DUTY_PROG_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_dty  <= DEF_N >> 1;
      r_pdty <= DEF_N >> 1;
    end else begin
      r_dty <= w_dty_nxt;
      if (w_take) r_pdty <= bus.duty_i;
    end
`endif
  clk_div_phase_gen #(.W(W)) u_phase (
    .clk    (clk),
    .reset_n(reset_n),
    .i_run  (w_st_nxt == ST_RUN),
    .i_cnt  (w_cnt_nxt),
`ifdef CLK_DIV_DUTY_PROG_EN
    .i_duty (w_dty_nxt),
`else
    .i_n    (w_div_nxt),
`endif
    .o_clk  (bus.clk_out)
  );
  assign bus.div_ack = r_ack;
  assign bus.div_err = r_err;
  assign bus.div_cur = r_div;
  assign bus.busy    = r_busy;
  assign bus.tick    = (r_st == ST_RUN) & (r_cnt == '0);
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed checks of ratio, duty, handshake, enable and reset of clk_div_prog
module tb_clk_div_prog;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic got;
  int n_chk = 0, n_fail = 0, ack_cnt = 0, a0, a1;
  longint t, tp, tr, te;
  clk_div_prog_if #(.W(8)) b();
  clk_div_prog #(.W(8), .DEFAULT_DIV(7)) dut (.clk(clk), .reset_n(reset_n), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) if (b.div_ack === 1'b1) ack_cnt <= ack_cnt + 1;
  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wclk(input logic rise, input string tag, output longint tt);
    got = 1'b0;
    fork
      begin
        if (rise) @(posedge b.clk_out);
        else @(negedge b.clk_out);
        got = 1'b1;
      end
      #2000;
    join_any
    disable fork;
    tt = $time;
    if (!got) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: no clk_out edge within bound", tag);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    b.en = 1'b1;
    b.div_load = 1'b0;
    b.div_i = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_clk_out", b.clk_out, 0);
    chk("rst_tick", b.tick, 0);
    chk("rst_ack", b.div_ack, 0);
    chk("rst_err", b.div_err, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_cur", b.div_cur, 7);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    wclk(1, "a_rise0", tr);
    chk("a_first_rise", tr, 25);
    wclk(0, "a_fall", t);
    chk("a_high", t - tr, 35);
    wclk(1, "a_rise1", t);
    chk("a_period", t - tr, 70);
    tp = t;
    #1 chk("a_tick", b.tick, 1);
    cyc(1);
    chk("a_tick_low", b.tick, 0);
    b.div_i = 8'd1;
    b.div_load = 1'b1;
    cyc(1);
    chk("d_err1", b.div_err, 1);
    chk("d_busy1", b.busy, 0);
    b.div_i = 8'd0;
    cyc(1);
    b.div_load = 1'b0;
    chk("d_err0", b.div_err, 1);
    chk("d_cur", b.div_cur, 7);
    cyc(1);
    chk("d_err_low", b.div_err, 0);
    wclk(1, "d_rise", t);
    chk("d_period", t - tp, 70);
    tp = t;
    #1;
    cyc(2);
    b.div_i = 8'd4;
    b.div_load = 1'b1;
    cyc(1);
    b.div_load = 1'b0;
    chk("b_busy", b.busy, 1);
    chk("b_cur_old", b.div_cur, 7);
    chk("b_ack_early", b.div_ack, 0);
    wclk(1, "b_rise", t);
    chk("b_bnd", t - tp, 70);
    tp = t;
    #1;
    chk("b_ack", b.div_ack, 1);
    chk("b_busy_clr", b.busy, 0);
    chk("b_cur", b.div_cur, 4);
    chk("b_tick", b.tick, 1);
    cyc(1);
    chk("b_ack_low", b.div_ack, 0);
    wclk(0, "b_fall", t);
    chk("b_high", t - tp, 20);
    wclk(1, "b_rise1", t);
    chk("b_period", t - tp, 40);
    tp = t;
    #1;
    b.div_i = 8'd5;
    b.div_load = 1'b1;
    cyc(1);
    b.div_i = 8'd6;
    cyc(1);
    b.div_load = 1'b0;
    chk("c_busy", b.busy, 1);
    chk("c_cur_old", b.div_cur, 4);
    a0 = ack_cnt;
    wclk(1, "c_rise", t);
    chk("c_bnd", t - tp, 40);
    tp = t;
    #1;
    chk("c_cur", b.div_cur, 6);
    chk("c_ack", b.div_ack, 1);
    wclk(0, "c_fall", t);
    chk("c_high", t - tp, 30);
    wclk(1, "c_rise1", t);
    chk("c_period", t - tp, 60);
    tp = t;
    chk("c_one_ack", ack_cnt - a0, 1);
    #1;
    b.div_i = 8'd7;
    b.div_load = 1'b1;
    cyc(1);
    b.div_load = 1'b0;
    wclk(1, "e_rise", t);
    chk("e_bnd", t - tp, 60);
    tp = t;
    #1 chk("e_cur", b.div_cur, 7);
    cyc(2);
    b.en = 1'b0;
    wclk(0, "e_fall", t);
    chk("e_high", t - tp, 35);
    cyc(4);
    chk("e_off_clk", b.clk_out, 0);
    chk("e_off_tick", b.tick, 0);
    cyc(3);
    chk("e_off_clk2", b.clk_out, 0);
    chk("e_off_tick2", b.tick, 0);
    te = $time - 1;
    b.en = 1'b1;
    wclk(1, "e_rise_on", t);
    chk("e_restart", t - te, 10);
    tp = t;
    wclk(0, "e_fall_on", t);
    chk("e_high_on", t - tp, 35);
    wclk(1, "f_rise", t);
    chk("f_period", t - tp, 70);
    #1;
    b.div_i = 8'd3;
    b.div_load = 1'b1;
    cyc(1);
    b.div_load = 1'b0;
    chk("f_busy", b.busy, 1);
    a1 = ack_cnt;
    #1 reset_n = 1'b0;
    #1;
    chk("f_async_clk", b.clk_out, 0);
    chk("f_rst_busy", b.busy, 0);
    chk("f_rst_cur", b.div_cur, 7);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tr = $time - 1;
    wclk(1, "f_rise_rel", t);
    chk("f_first_rise", t - tr, 10);
    tp = t;
    #1;
    chk("f_cur", b.div_cur, 7);
    chk("f_busy_rel", b.busy, 0);
    wclk(0, "f_fall", t);
    chk("f_high", t - tp, 35);
    wclk(1, "f_rise1", t);
    chk("f_period7", t - tp, 70);
    chk("f_no_ack", ack_cnt - a1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider: divides `clk` by any ratio 2..2^W-1, odd or even.
- 50% duty output; for odd ratios the half-cycle is resolved on the negedge.
- The new ratio is taken at a period boundary through a load/ack handshake, so `clk_out` never glitches or produces a runt pulse.
- Sits in the clock/reset unit and feeds derived clocks to peripheral domains, together with a one-cycle period tick in the source domain.

Parameters:
- W, 8, width of the ratio register and counters.
- DEFAULT_DIV, 7, ratio loaded at reset; must lie in 2..2^W-1.

Ports:
- clk  in  1  source clock.
- reset_n  in  1  asynchronous active-low reset; asserts asynchronously, deasserts synchronous to `clk` (synchronised upstream).
- en  in  1  run enable; sampled on posedge.
- div_i  in  W  requested divide ratio.
- div_load  in  1  one-cycle request to adopt `div_i`.
- div_ack  out  1  one-cycle pulse when the pending ratio becomes active.
- div_err  out  1  one-cycle pulse when a load is rejected.
- div_cur  out  W  currently active ratio.
- busy  out  1  high while a load is pending (accepted, not yet applied).
- tick  out  1  one-cycle posedge-domain pulse on the first `clk` of each output period.
- clk_out  out  1  divided clock.

Behaviour:
- Reset (reset_n=0):
  - pos/neg counters = 0; active ratio = DEFAULT_DIV; pending cleared.
  - clk_out=0, tick=0, div_ack=0, div_err=0, busy=0.
- Counter:
  - pos_cnt runs 0..N-1 on posedge, where N is the active ratio.
  - The wrap to 0 is the period boundary.
  - tick=1 during the cycle pos_cnt==0 while running.
- Waveform:
  - clk_out rises at the posedge beginning pos_cnt==0.
  - Even N: high for N/2 clk periods, falls on a posedge.
  - Odd N: high for (N-1)/2 + 0.5 periods, falls on the negedge inside pos_cnt==(N-1)/2.
  - Output is the OR/selection of registered posedge and negedge flops only; no combinational compare drives clk_out.
- Load handshake:
  - div_load with div_i in 2..2^W-1: div_i latched as pending, busy=1 from next cycle.
  - At the next period boundary: active ratio = pending, div_cur updates, div_ack pulses for one cycle, busy=0.
  - The first period of the new ratio starts on that boundary.
  - A new div_load while busy overwrites pending; only one ack is issued.
  - div_load with div_i of 0 or 1: rejected, div_err pulses the next cycle, pending and active unchanged.
  - A rejected load while busy leaves the earlier pending value intact.
- Enable:
  - en=0: the current period completes; at the boundary the counter holds at 0, clk_out stays 0, tick=0.
  - A pending load is still applied at that boundary.
  - en=1 again: the next posedge starts a period, so clk_out rises one cycle later.
  - en=0 sampled before the first period after reset: clk_out stays 0.
- Reset mid-period: clk_out drops immediately (asynchronous), any pending load is discarded, DEFAULT_DIV is restored.
- Negedge logic resets with the same reset_n and follows the posedge counter state; it never free-runs independently.

Optional Feature:
- Macro: CLK_DIV_DUTY_PROG_EN.
- Defined:
  - Adds input duty_i [W-1:0], latched together with div_i on load.
  - clk_out is high for duty_i posedge-aligned cycles; no half-cycle, negedge logic removed.
  - A load with duty_i==0 or duty_i>=div_i is rejected via div_err.
- Undefined: fixed 50% behaviour as above; no duty_i port.

Decomposition:
- Package clk_div_pkg:
  - typedef div_t (logic [W-1:0] with W at package default 8);
  - constants DIV_MIN=2 and DEFAULT_DIV;
  - function is_legal_div.
- One sub-module, clk_div_phase_gen: takes active N and pos_cnt, produces the glitch-free posedge/negedge high-phase flops and clk_out.
- Handshake and counter stay in the top level.

Test Plan:
- Reset release with en=1, DEFAULT_DIV=7 -> clk_out period 7 clk, high 3.5 clk, rising 1 clk after release; tick every 7 cycles.
- div_i=4 load mid-period -> busy=1 until boundary; div_ack one cycle at boundary; then period 4, high exactly 2 clk; div_cur=4.
- Loads of 5 then 6 in consecutive cycles within one period -> single div_ack; next period 6; no runt pulse on clk_out.
- div_i=1 and div_i=0 loads -> div_err pulse each; div_cur and period unchanged (7).
- en=0 at pos_cnt=2 of N=7 -> period completes, clk_out low and tick=0 while disabled; en=1 -> rising edge 1 cycle later with full 3.5-clk high phase.
- reset_n asserted mid high-phase with a load pending -> clk_out=0 asynchronously; after release ratio=DEFAULT_DIV, busy=0, no div_ack.
